// File: rtl/gameserver_pkg.sv
// gameserver_pkg: constants, state encoding and field-widening helpers for
// the state-frame transmitter.
//
// Contents:
//   COORD_W / SCORE_W       field widths on the input buses
//   BALL_CNT / PADDLE_CNT   number of balls and paddles in a snapshot
//   BODY_BYTES / WORD_W     body length in bytes and width of one body word
//   DEFAULT_HEADER          frame start byte used when HEADER is not overridden
//   frame_state_t           FSM state encoding (SEQ exists only with STATE_FRAME_SEQ_EN)
//   sext_coord / zext_score widen a field to one 16-bit body word
package gameserver_pkg;

    localparam int COORD_W    = 11;
    localparam int SCORE_W    = 9;
    localparam int BALL_CNT   = 5;
    localparam int PADDLE_CNT = 4;
    localparam int BODY_BYTES = 32;
    localparam int WORD_W     = 16;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
`ifdef STATE_FRAME_SEQ_EN
        SEQ  = 3'd2,
`endif
        BODY = 3'd3,
        CSUM = 3'd4
    } frame_state_t;

    function automatic logic [WORD_W-1:0] sext_coord(input logic [COORD_W-1:0] c);
        return {{(WORD_W-COORD_W){c[COORD_W-1]}}, c};
    endfunction

    function automatic logic [WORD_W-1:0] zext_score(input logic [SCORE_W-1:0] s);
        return {{(WORD_W-SCORE_W){1'b0}}, s};
    endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// frame_byte_sel: combinational selector that turns a body byte index into
// the matching byte of the captured snapshot.
//
// Ports:
//   shadow_x   in   captured ball x positions (ball i at [11i+10:11i])
//   shadow_y   in   captured ball y positions
//   shadow_p   in   captured paddle y positions (paddle 0..3)
//   shadow_l   in   captured left score
//   shadow_r   in   captured right score
//   byte_idx   in   body byte index 0..31
//   body_byte  out  selected byte
//
// Word order: ball0 x, ball0 y, ... ball4 x, ball4 y, paddle0..3 y, l, r.
// Each word is sent high byte first, so byte_idx[0]=0 picks the high byte.
module frame_byte_sel
    import gameserver_pkg::*;
(
    input  logic [BALL_CNT*COORD_W-1:0]   shadow_x,
    input  logic [BALL_CNT*COORD_W-1:0]   shadow_y,
    input  logic [PADDLE_CNT*COORD_W-1:0] shadow_p,
    input  logic [SCORE_W-1:0]            shadow_l,
    input  logic [SCORE_W-1:0]            shadow_r,
    input  logic [4:0]                    byte_idx,
    output logic [7:0]                    body_byte
);

    logic [3:0]         word_idx;
    logic [2:0]         ball;
    logic [1:0]         pad;
    logic [COORD_W-1:0] coord;
    logic [WORD_W-1:0]  word;

    always_comb begin
        word_idx = byte_idx[4:1];
        ball     = '0;
        pad      = '0;
        coord    = '0;
        word     = '0;
        if (word_idx < 4'd10) begin
            // even word = x, odd word = y of the same ball
            ball  = word_idx[3:1];
            coord = word_idx[0] ? shadow_y[int'(ball)*COORD_W +: COORD_W]
                                : shadow_x[int'(ball)*COORD_W +: COORD_W];
            word  = sext_coord(coord);
        end else if (word_idx < 4'd14) begin
            pad   = 2'(word_idx - 4'd10);
            coord = shadow_p[int'(pad)*COORD_W +: COORD_W];
            word  = sext_coord(coord);
        end else if (word_idx == 4'd14) begin
            word  = zext_score(shadow_l);
        end else begin
            word  = zext_score(shadow_r);
        end
        body_byte = byte_idx[0] ? word[7:0] : word[15:8];
    end

endmodule

// File: rtl/state_frame_tx.sv
// state_frame_tx: snapshots the game state on stclk and streams it as a byte
// frame over a valid/ready interface.
//
// Frame: HEADER, [SEQ], 32 body bytes, CSUM (XOR of every byte after HEADER).
// Optional feature macro: STATE_FRAME_SEQ_EN adds an 8-bit frame sequence
// byte after HEADER; it counts completed frames and wraps.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous reset, active HIGH despite the name
//   stclk         in   one-cycle snapshot strobe
//   ball_x_bus    in   5 x signed 11-bit ball x
//   ball_y_bus    in   5 x signed 11-bit ball y
//   paddle_y_bus  in   4 x signed 11-bit paddle y
//   l_score       in   unsigned 9-bit left score
//   r_score       in   unsigned 9-bit right score
//   tx_data       out  current byte
//   tx_valid      out  tx_data valid
//   tx_ready      in   sink accepts tx_data
//   busy          out  frame in progress
//   frame_done    out  one-cycle pulse after the CSUM byte is accepted
//   drop_cnt      out  saturating count of strobes ignored while busy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for stclk; snapshot captured on the strobe
// HDR   | HEADER byte presented
// SEQ   | sequence byte presented (STATE_FRAME_SEQ_EN only)
// BODY  | body byte byte_idx presented
// CSUM  | checksum byte presented
module state_frame_tx
    import gameserver_pkg::*;
#(
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stclk,
    input  logic [BALL_CNT*COORD_W-1:0]   ball_x_bus,
    input  logic [BALL_CNT*COORD_W-1:0]   ball_y_bus,
    input  logic [PADDLE_CNT*COORD_W-1:0] paddle_y_bus,
    input  logic [SCORE_W-1:0]            l_score,
    input  logic [SCORE_W-1:0]            r_score,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic [7:0]                    drop_cnt
);

    frame_state_t                  state;
    logic [4:0]                    byte_idx;
    logic [4:0]                    sel_idx;
    logic [7:0]                    body_byte;
    logic [7:0]                    csum;
    logic [BALL_CNT*COORD_W-1:0]   shadow_x;
    logic [BALL_CNT*COORD_W-1:0]   shadow_y;
    logic [PADDLE_CNT*COORD_W-1:0] shadow_p;
    logic [SCORE_W-1:0]            shadow_l;
    logic [SCORE_W-1:0]            shadow_r;
`ifdef STATE_FRAME_SEQ_EN
    logic [7:0]                    seq_cnt;
`endif

    // tx_data is registered, so the selector always looks one byte ahead:
    // index 0 while leaving HDR/SEQ, byte_idx+1 while inside BODY.
    assign sel_idx = (state == BODY) ? byte_idx + 5'd1 : 5'd0;

    frame_byte_sel u_sel (
        .shadow_x  (shadow_x),
        .shadow_y  (shadow_y),
        .shadow_p  (shadow_p),
        .shadow_l  (shadow_l),
        .shadow_r  (shadow_r),
        .byte_idx  (sel_idx),
        .body_byte (body_byte)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            csum       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_p   <= '0;
            shadow_l   <= '0;
            shadow_r   <= '0;
`ifdef STATE_FRAME_SEQ_EN
            seq_cnt    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;

            // Strobes outside IDLE are lost, including the CSUM-accept cycle.
            if (stclk && (state != IDLE) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (stclk) begin
                        shadow_x <= ball_x_bus;
                        shadow_y <= ball_y_bus;
                        shadow_p <= paddle_y_bus;
                        shadow_l <= l_score;
                        shadow_r <= r_score;
                        csum     <= '0;
                        byte_idx <= '0;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
                        state    <= HDR;
                    end
                end

                HDR: begin
                    if (tx_ready) begin
`ifdef STATE_FRAME_SEQ_EN
                        tx_data  <= seq_cnt;
                        state    <= SEQ;
`else
                        tx_data  <= body_byte;
                        byte_idx <= '0;
                        state    <= BODY;
`endif
                    end
                end

`ifdef STATE_FRAME_SEQ_EN
                SEQ: begin
                    if (tx_ready) begin
                        csum     <= csum ^ tx_data;
                        tx_data  <= body_byte;
                        byte_idx <= '0;
                        state    <= BODY;
                    end
                end
`endif

                BODY: begin
                    if (tx_ready) begin
                        csum <= csum ^ tx_data;
                        if (byte_idx == 5'(BODY_BYTES-1)) begin
                            // final body byte folds into the checksum on the way out
                            tx_data <= csum ^ tx_data;
                            state   <= CSUM;
                        end else begin
                            tx_data  <= body_byte;
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end

                CSUM: begin
                    if (tx_ready) begin
                        tx_data    <= '0;
                        tx_valid   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
`ifdef STATE_FRAME_SEQ_EN
                        seq_cnt    <= seq_cnt + 8'd1;
`endif
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
